// File: rtl/regfile_scoreboard.sv
// Register file with E/M write ports, write-through read bypass and a per-register pending-write scoreboard.
// Latency: reads and bypass are combinational; writes and scoreboard updates land on the next rising edge.
// Backpressure: issue_ready drops when the destination's pending count would pass PMAX; a refused issue is dropped, so decode stalls.
//
// Ports:
//   clock, reset            : rising-edge clock, asynchronous active-low reset
//   srcA/srcB -> valA/valB  : combinational reads (zero reg, then M, then E bypass, then storage)
//   wenE/dstE/valE          : E write port
//   wenM/dstM/valM          : M write port (wins over E on the same destination)
//   issue_valid/issue_dst   : records one pending write; issue_ready says whether it is taken
//   srcA_busy/srcB_busy     : source still has a pending write that does not retire this cycle
//   err                     : sticky pending-count underflow
module regfile_scoreboard #(
  parameter int WIDTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int PEND_W   = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] srcA,
  input  logic [ADDR_W-1:0] srcB,
  output logic [WIDTH-1:0]  valA,
  output logic [WIDTH-1:0]  valB,
  input  logic              wenE,
  input  logic [ADDR_W-1:0] dstE,
  input  logic [WIDTH-1:0]  valE,
  input  logic              wenM,
  input  logic [ADDR_W-1:0] dstM,
  input  logic [WIDTH-1:0]  valM,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_dst,
  output logic              issue_ready,
  output logic              srcA_busy,
  output logic              srcB_busy,
  output logic              err
);

  localparam int NREGS = 2**ADDR_W;
  localparam int PMAX  = 2**PEND_W - 1;
  // Two guard bits: cnt + inc can reach PMAX+1 and dec can reach 2.
  localparam int CW    = PEND_W + 2;

  logic [WIDTH-1:0]  regs_q [NREGS];
  logic [WIDTH-1:0]  regs_d [NREGS];
  logic [PEND_W-1:0] cnt_q  [NREGS];
  logic [PEND_W-1:0] cnt_d  [NREGS];
  logic              err_q, err_d;

  // Number of writes retiring to each register this cycle (0..2).
  logic [1:0] dec [NREGS];

  logic zero_a, zero_b, zero_iss;
  logic we_e, we_m;
  logic issue_acc;
  logic [CW-1:0] iss_cnt, iss_dec, iss_left;

  assign zero_a   = (ZERO_REG != 0) && (srcA == '0);
  assign zero_b   = (ZERO_REG != 0) && (srcB == '0);
  assign zero_iss = (ZERO_REG != 0) && (issue_dst == '0);
  assign we_e     = wenE && !((ZERO_REG != 0) && (dstE == '0));
  assign we_m     = wenM && !((ZERO_REG != 0) && (dstM == '0));

  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      dec[r] = {1'b0, wenE && (dstE == ADDR_W'(r))} + {1'b0, wenM && (dstM == ADDR_W'(r))};
    end
  end

  // Read ports: M bypass is checked before E so a read sees what will be stored.
  assign valA = zero_a ? '0 :
                (wenM && dstM == srcA) ? valM :
                (wenE && dstE == srcA) ? valE : regs_q[srcA];
  assign valB = zero_b ? '0 :
                (wenM && dstM == srcB) ? valM :
                (wenE && dstE == srcB) ? valE : regs_q[srcB];

  // Issue headroom is judged after this cycle's retirements, so a full
  // register that is retiring can accept a new issue in the same cycle.
  assign iss_cnt     = CW'(cnt_q[issue_dst]);
  assign iss_dec     = CW'(dec[issue_dst]);
  assign iss_left    = (iss_cnt > iss_dec) ? (iss_cnt - iss_dec) : '0;
  assign issue_ready = zero_iss || (iss_left < CW'(PMAX));
  assign issue_acc   = issue_valid && issue_ready && !zero_iss;

  // A source whose last pending write retires now is not busy: bypass covers it.
  assign srcA_busy = CW'(cnt_q[srcA]) > CW'(dec[srcA]);
  assign srcB_busy = CW'(cnt_q[srcB]) > CW'(dec[srcB]);
  assign err       = err_q;

  always_comb begin
    regs_d = regs_q;
    if (we_e) regs_d[dstE] = valE;
    if (we_m) regs_d[dstM] = valM;
  end

  always_comb begin
    logic [CW-1:0] sum;
    sum   = '0;
    err_d = err_q;
    for (int r = 0; r < NREGS; r++) begin
      cnt_d[r] = cnt_q[r];
      if (!((ZERO_REG != 0) && (r == 0))) begin
        sum = CW'(cnt_q[r]) + CW'(issue_acc && (issue_dst == ADDR_W'(r)));
        if (sum < CW'(dec[r])) begin
          // Retirement without a matching issue: clamp and flag.
          cnt_d[r] = '0;
          err_d    = 1'b1;
        end else begin
          cnt_d[r] = PEND_W'(sum - CW'(dec[r]));
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NREGS; r++) begin
        regs_q[r] <= '0;
        cnt_q[r]  <= '0;
      end
      err_q <= 1'b0;
    end else begin
      regs_q <= regs_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
module tb_regfile_scoreboard;

  localparam int W    = 32;
  localparam int AW   = 5;
  localparam int N    = 32;
  localparam int PMAX = 3;

  logic          clock = 1'b0;
  logic          reset;
  logic [AW-1:0] srcA, srcB, dstE, dstM, issue_dst;
  logic [W-1:0]  valE, valM;
  logic          wenE, wenM, issue_valid;

  // suffix 1 = ZERO_REG=1 instance, suffix 0 = ZERO_REG=0 instance
  logic [W-1:0] valA1, valB1, valA0, valB0;
  logic         rdy1, rdy0, ba1, bb1, ba0, bb0, err1, err0;

  int checks = 0;
  int errors = 0;

  // Reference model state, first index = ZERO_REG setting of the instance.
  logic [W-1:0] mreg [2][N];
  int           mcnt [2][N];
  bit           merr [2];

  always #5 clock = ~clock;

  regfile_scoreboard #(.WIDTH(W), .ADDR_W(AW), .ZERO_REG(1), .PEND_W(2)) dut (
    .clock(clock), .reset(reset), .srcA(srcA), .srcB(srcB), .valA(valA1), .valB(valB1),
    .wenE(wenE), .dstE(dstE), .valE(valE), .wenM(wenM), .dstM(dstM), .valM(valM),
    .issue_valid(issue_valid), .issue_dst(issue_dst), .issue_ready(rdy1),
    .srcA_busy(ba1), .srcB_busy(bb1), .err(err1));

  regfile_scoreboard #(.WIDTH(W), .ADDR_W(AW), .ZERO_REG(0), .PEND_W(2)) dut0 (
    .clock(clock), .reset(reset), .srcA(srcA), .srcB(srcB), .valA(valA0), .valB(valB0),
    .wenE(wenE), .dstE(dstE), .valE(valE), .wenM(wenM), .dstM(dstM), .valM(valM),
    .issue_valid(issue_valid), .issue_dst(issue_dst), .issue_ready(rdy0),
    .srcA_busy(ba0), .srcB_busy(bb0), .err(err0));

  function automatic int mdec(int r);
    return int'(wenE && (int'(dstE) == r)) + int'(wenM && (int'(dstM) == r));
  endfunction

  function automatic logic [W-1:0] mread(int z, int src);
    if (z == 1 && src == 0) return '0;
    if (wenM && int'(dstM) == src) return valM;
    if (wenE && int'(dstE) == src) return valE;
    return mreg[z][src];
  endfunction

  function automatic bit mready(int z);
    int left;
    if (z == 1 && issue_dst == 0) return 1'b1;
    left = mcnt[z][issue_dst] - mdec(int'(issue_dst));
    if (left < 0) left = 0;
    return left < PMAX;
  endfunction

  function automatic bit mbusy(int z, int src);
    return mcnt[z][src] > mdec(src);
  endfunction

  task automatic model_reset();
    for (int z = 0; z < 2; z++) begin
      for (int r = 0; r < N; r++) begin
        mreg[z][r] = '0;
        mcnt[z][r] = 0;
      end
      merr[z] = 1'b0;
    end
  endtask

  task automatic model_edge();
    for (int z = 0; z < 2; z++) begin
      bit acc;
      int v;
      acc = issue_valid && mready(z);
      if (wenE && !(z == 1 && dstE == 0)) mreg[z][dstE] = valE;
      if (wenM && !(z == 1 && dstM == 0)) mreg[z][dstM] = valM;
      for (int r = 0; r < N; r++) begin
        if (z == 1 && r == 0) continue;
        v = mcnt[z][r] + int'(acc && int'(issue_dst) == r) - mdec(r);
        if (v < 0) begin
          v = 0;
          merr[z] = 1'b1;
        end
        mcnt[z][r] = v;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".valA1"}, valA1, mread(1, int'(srcA)));
    chk({tag, ".valB1"}, valB1, mread(1, int'(srcB)));
    chk({tag, ".rdy1"},  W'(rdy1), W'(mready(1)));
    chk({tag, ".busyA1"}, W'(ba1), W'(mbusy(1, int'(srcA))));
    chk({tag, ".busyB1"}, W'(bb1), W'(mbusy(1, int'(srcB))));
    chk({tag, ".err1"},  W'(err1), W'(merr[1]));
    chk({tag, ".valA0"}, valA0, mread(0, int'(srcA)));
    chk({tag, ".valB0"}, valB0, mread(0, int'(srcB)));
    chk({tag, ".rdy0"},  W'(rdy0), W'(mready(0)));
    chk({tag, ".busyA0"}, W'(ba0), W'(mbusy(0, int'(srcA))));
    chk({tag, ".busyB0"}, W'(bb0), W'(mbusy(0, int'(srcB))));
    chk({tag, ".err0"},  W'(err0), W'(merr[0]));
  endtask

  // Inputs change on the falling edge; outputs are checked 1 time unit later.
  task automatic settle(input string tag);
    #1;
    compare_all(tag);
  endtask

  task automatic tick();
    @(posedge clock);
    if (reset) model_edge();
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    wenE = 1'b0; wenM = 1'b0; issue_valid = 1'b0;
    dstE = '0; dstM = '0; issue_dst = '0;
    valE = '0; valM = '0;
  endtask

  initial begin
    reset = 1'b0;
    srcA = '0; srcB = '0;
    idle_inputs();
    model_reset();
    @(negedge clock);

    // Reset state
    settle("rst");
    chk("rst_valA", valA1, '0);
    chk("rst_ready", W'(rdy1), 1);
    chk("rst_err", W'(err1), 0);
    tick();

    // E write with same-cycle bypass, then stored read
    reset = 1'b1;
    wenE = 1'b1; dstE = 5'd8; valE = 32'h1234; srcA = 5'd8;
    settle("wr8");
    chk("bypass_e", valA1, 32'h1234);
    tick();
    wenE = 1'b0;
    settle("rd8");
    chk("stored8", valA1, 32'h1234);
    tick();

    // Simultaneous writes: M wins
    wenE = 1'b1; wenM = 1'b1; dstE = 5'd5; dstM = 5'd5;
    valE = 32'hAAAA; valM = 32'h5555; srcA = 5'd5;
    settle("wr5");
    chk("bypass_mprio", valA1, 32'h5555);
    tick();
    wenE = 1'b0; wenM = 1'b0;
    settle("rd5");
    chk("mprio", valA1, 32'h5555);

    // Register 0 write
    wenE = 1'b1; dstE = 5'd0; valE = 32'hFFFF; srcA = 5'd0;
    settle("wr0");
    chk("zero_bypass", valA1, '0);
    tick();
    wenE = 1'b0;
    settle("rd0");
    chk("zero_read", valA1, '0);
    chk("zero_busy", W'(ba1), 0);
    chk("zero_off_read", valA0, 32'hFFFF);
    tick();

    // Fill reg 9 to PMAX
    issue_valid = 1'b1; issue_dst = 5'd9; srcB = 5'd9;
    for (int i = 0; i < 3; i++) begin
      settle("iss9");
      chk("iss9_ready", W'(rdy1), 1);
      tick();
    end
    settle("iss9_full");
    chk("busy9", W'(bb1), 1);
    chk("full9", W'(rdy1), 0);
    tick();
    // Retire plus issue in one cycle: room opens, count stays at 3
    wenE = 1'b1; dstE = 5'd9; valE = 32'h99;
    settle("iss9_ret");
    chk("iss9_ret_ready", W'(rdy1), 1);
    tick();
    issue_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle("ret9");
      chk("ret9_busy", W'(bb1), W'(i < 2));
      tick();
    end
    wenE = 1'b0;
    settle("idle9");
    chk("idle9_busy", W'(bb1), 0);
    chk("idle9_val", valB1, 32'h99);
    tick();

    // Underflow: one issue, two retirements
    issue_valid = 1'b1; issue_dst = 5'd12;
    settle("iss12");
    tick();
    issue_valid = 1'b0;
    wenE = 1'b1; wenM = 1'b1; dstE = 5'd12; dstM = 5'd12;
    settle("ret12");
    tick();
    wenE = 1'b0; wenM = 1'b0; srcA = 5'd12;
    settle("err12");
    chk("err_set", W'(err1), 1);
    chk("err12_busy", W'(ba1), 0);
    tick();
    settle("err_hold");
    chk("err_sticky", W'(err1), 1);
    tick();

    // Mid-operation reset between edges
    issue_valid = 1'b1; issue_dst = 5'd3;
    wenE = 1'b1; dstE = 5'd4; valE = 32'd7;
    settle("pre_rst");
    tick();
    idle_inputs();
    srcA = 5'd4; srcB = 5'd3;
    settle("pre_rst2");
    chk("pre_rst_val", valA1, 32'd7);
    chk("pre_rst_busy", W'(bb1), 1);
    #1;
    reset = 1'b0;
    model_reset();
    settle("mid_rst");
    chk("mid_rst_val", valA1, '0);
    chk("mid_rst_busy", W'(bb1), 0);
    chk("mid_rst_err", W'(err1), 0);
    reset = 1'b1;
    tick();

    // Register 0 behaves normally in the ZERO_REG=0 instance
    wenE = 1'b1; dstE = 5'd0; valE = 32'h77;
    settle("z0_wr");
    tick();
    wenE = 1'b0; srcA = 5'd0;
    settle("z0_rd");
    chk("z0_read", valA0, 32'h77);
    chk("z1_read", valA1, '0);
    issue_valid = 1'b1; issue_dst = 5'd0;
    settle("z0_iss");
    tick();
    issue_valid = 1'b0;
    settle("z0_busy");
    chk("z0_busyA", W'(ba0), 1);
    chk("z1_busyA", W'(ba1), 0);
    tick();

    // Randomized traffic on a narrow register window to force collisions
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 63) == 0) begin
        reset = 1'b0;
        model_reset();
      end else begin
        reset = 1'b1;
      end
      srcA        = AW'($urandom_range(0, 7));
      srcB        = AW'($urandom_range(0, 7));
      wenE        = ($urandom_range(0, 2) == 0);
      wenM        = ($urandom_range(0, 2) == 0);
      dstE        = AW'($urandom_range(0, 7));
      dstM        = AW'($urandom_range(0, 7));
      valE        = $urandom;
      valM        = $urandom;
      issue_valid = ($urandom_range(0, 1) == 0);
      issue_dst   = AW'($urandom_range(0, 7));
      settle("rnd");
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
